mul_arbiter: RTL

- Round-robin arbiter and scheduler that shares one multiplier core among NUM_REQ requesters.
- Each requester gets a valid/ready request port and a held response slot.
- The arbiter issues at most one operation per cycle to the core, which has a 1-cycle registered latency, and tracks which requester owns each in-flight result.
- It routes each product back to its owner's result register and holds it until the owner accepts it.

---
 rtl/mul_arbiter_if.sv | 33 +++
 rtl/mul_arbiter.sv | 135 +++++++++++++
 2 files changed

// File: rtl/mul_arbiter_if.sv
// Bundle of request, multiplier-core and response signals for mul_arbiter.
// Every valid/ready pair transfers on a rising clk edge where both are 1; a held valid and its data stay stable until that edge.
interface mul_arbiter_if #(
    parameter int IN_DATA_WIDTH = 8,
    parameter int NUM_REQ       = 4
);
    logic [NUM_REQ-1:0]                 i_req_valid;
    logic [NUM_REQ-1:0]                 o_req_ready;
    logic [NUM_REQ*IN_DATA_WIDTH-1:0]   i_req_a;
    logic [NUM_REQ*IN_DATA_WIDTH-1:0]   i_req_b;
    logic                               o_mul_valid;
    logic [IN_DATA_WIDTH-1:0]           o_mul_a;
    logic [IN_DATA_WIDTH-1:0]           o_mul_b;
    logic                               i_mul_valid;
    logic [2*IN_DATA_WIDTH-1:0]         i_mul_result;
    logic [NUM_REQ-1:0]                 o_rsp_valid;
    logic [NUM_REQ-1:0]                 i_rsp_ready;
    logic [NUM_REQ*2*IN_DATA_WIDTH-1:0] o_rsp_result;
    logic [NUM_REQ-1:0]                 o_busy;
    logic                               o_err;

    modport slave (
        input  i_req_valid, i_req_a, i_req_b, i_mul_valid, i_mul_result, i_rsp_ready,
        output o_req_ready, o_mul_valid, o_mul_a, o_mul_b, o_rsp_valid, o_rsp_result,
        output o_busy, o_err
    );

    modport master (
        output i_req_valid, i_req_a, i_req_b, i_mul_valid, i_mul_result, i_rsp_ready,
        input  o_req_ready, o_mul_valid, o_mul_a, o_mul_b, o_rsp_valid, o_rsp_result,
        input  o_busy, o_err
    );
endinterface

// File: rtl/mul_arbiter.sv
// Round-robin scheduler sharing one 1-cycle multiplier core among NUM_REQ requesters,
// with a two-stage owner tag pipeline and a held result slot per requester.
module mul_arbiter #(
    parameter int IN_DATA_WIDTH = 8,
    parameter int NUM_REQ       = 4
) (
    input logic          clk,
    input logic          reset,
    mul_arbiter_if.slave bus
);
    localparam int W    = IN_DATA_WIDTH;
    localparam int PW   = 2 * IN_DATA_WIDTH;
    localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [ID_W-1:0] LAST_ID = ID_W'(NUM_REQ - 1);

    logic [ID_W-1:0]       ptr_q, ptr_d;
    logic [NUM_REQ-1:0]    busy_q, busy_d;
    logic [NUM_REQ-1:0]    rsp_valid_q, rsp_valid_d;
    logic [NUM_REQ*PW-1:0] rsp_result_q, rsp_result_d;
    logic                  tag1_v_q, tag1_v_d;
    logic [ID_W-1:0]       tag1_id_q, tag1_id_d;
    logic                  tag2_v_q, tag2_v_d;
    logic [ID_W-1:0]       tag2_id_q, tag2_id_d;
    logic [W-1:0]          mul_a_q, mul_a_d;
    logic [W-1:0]          mul_b_q, mul_b_d;
    logic                  err_q, err_d;

    logic [NUM_REQ-1:0]    eligible;
    logic [NUM_REQ-1:0]    grant_oh;
    logic                  grant_v;
    logic [ID_W-1:0]       grant_id;
    logic                  accept;

    // Search starts at ptr and wraps; the first eligible candidate wins.
    always_comb begin
        logic [ID_W:0] cand;
        eligible = bus.i_req_valid & ~busy_q;
        grant_v  = 1'b0;
        grant_id = '0;
        cand     = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = {1'b0, ptr_q} + (ID_W+1)'(i);
            if (cand >= (ID_W+1)'(NUM_REQ)) begin
                cand = cand - (ID_W+1)'(NUM_REQ);
            end
            if (!grant_v && eligible[cand[ID_W-1:0]]) begin
                grant_v  = 1'b1;
                grant_id = cand[ID_W-1:0];
            end
        end
        grant_oh = '0;
        if (grant_v && !reset) begin
            grant_oh[grant_id] = 1'b1;
        end
    end

    // Ready is only raised for a valid requester, so any ready bit is a completed handshake.
    assign accept = |grant_oh;

    always_comb begin
        ptr_d        = ptr_q;
        busy_d       = busy_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_result_d = rsp_result_q;
        tag1_v_d     = accept;
        tag1_id_d    = tag1_id_q;
        tag2_v_d     = tag1_v_q;
        tag2_id_d    = tag1_id_q;
        mul_a_d      = mul_a_q;
        mul_b_d      = mul_b_q;
        err_d        = err_q;

        for (int k = 0; k < NUM_REQ; k++) begin
            if (rsp_valid_q[k] && bus.i_rsp_ready[k]) begin
                rsp_valid_d[k] = 1'b0;
                busy_d[k]      = 1'b0;
            end
        end

        if (accept) begin
            ptr_d            = (grant_id == LAST_ID) ? '0 : grant_id + ID_W'(1);
            busy_d[grant_id] = 1'b1;
            tag1_id_d        = grant_id;
            mul_a_d          = bus.i_req_a[int'(grant_id)*W +: W];
            mul_b_d          = bus.i_req_b[int'(grant_id)*W +: W];
        end

        // A result with no owner in stage 2 is dropped and latched as a protocol error.
        if (bus.i_mul_valid) begin
            if (tag2_v_q) begin
                rsp_valid_d[tag2_id_q]                  = 1'b1;
                rsp_result_d[int'(tag2_id_q)*PW +: PW] = bus.i_mul_result;
            end else begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q        <= '0;
            busy_q       <= '0;
            rsp_valid_q  <= '0;
            rsp_result_q <= '0;
            tag1_v_q     <= 1'b0;
            tag1_id_q    <= '0;
            tag2_v_q     <= 1'b0;
            tag2_id_q    <= '0;
            mul_a_q      <= '0;
            mul_b_q      <= '0;
            err_q        <= 1'b0;
        end else begin
            ptr_q        <= ptr_d;
            busy_q       <= busy_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_result_q <= rsp_result_d;
            tag1_v_q     <= tag1_v_d;
            tag1_id_q    <= tag1_id_d;
            tag2_v_q     <= tag2_v_d;
            tag2_id_q    <= tag2_id_d;
            mul_a_q      <= mul_a_d;
            mul_b_q      <= mul_b_d;
            err_q        <= err_d;
        end
    end

    assign bus.o_req_ready  = grant_oh;
    assign bus.o_mul_valid  = tag1_v_q;
    assign bus.o_mul_a      = mul_a_q;
    assign bus.o_mul_b      = mul_b_q;
    assign bus.o_rsp_valid  = rsp_valid_q;
    assign bus.o_rsp_result = rsp_result_q;
    assign bus.o_busy       = busy_q;
    assign bus.o_err        = err_q;
endmodule
